// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types for the MIPS memory responder.
package mips_mem_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {LD_LOAD, LD_RUN, LD_ERR} ld_state_t;
endpackage

// File: rtl/mips_mem_loader.sv
// mips_mem_loader: boot loader FSM; streams the program into RAM while the core is held in reset.
module mips_mem_loader import mips_mem_pkg::*; #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_reset,
    output logic              load_err,
    output logic              run,
    output logic              we,
    output logic [AW-1:0]     widx,
    output logic [WORD_W-1:0] wdata
);
    ld_state_t state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LD_LOAD;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Outputs are gated by reset so nothing is accepted or released while it is held.
    always_comb begin
        ld_ready  = !reset && state_q == LD_LOAD;
        we        = ld_valid && ld_ready;
        widx      = wr_cnt_q;
        wdata     = ld_data;
        wr_cnt_d  = we ? wr_cnt_q + 1'b1 : wr_cnt_q;
        state_d   = state_q;
        if (we && ld_last)
            state_d = LD_RUN;
        else if (we && wr_cnt_q == AW'(DEPTH_WORDS - 1))
            state_d = LD_ERR;
        run       = !reset && state_q == LD_RUN;
        cpu_reset = !run;
        load_err  = !reset && state_q == LD_ERR;
    end
endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: word RAM serving MIPS fetch and load/store ports, preloaded by a stream loader.
// Define MIPS_MEM_MMIO_EN to route stores at MMIO_ADDR to the console strobe instead of RAM.
module mips_mem_responder import mips_mem_pkg::*; #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_reset,
    output logic              load_err,
    input  logic [31:0]       instr_addr,
    output logic [WORD_W-1:0] instr_in,
    input  logic [31:0]       data_addr,
    input  logic              data_rd_wr,
    input  logic [WORD_W-1:0] data_out,
    output logic [WORD_W-1:0] data_in,
    output logic              mmio_valid,
    output logic [WORD_W-1:0] mmio_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
`ifdef MIPS_MEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic              ld_we, run, i_hit, d_hit, d_mmio, mem_we;
    logic [AW-1:0]     ld_widx, mem_widx;
    logic [WORD_W-1:0] ld_wdata, mem_wdata;
    logic [31:0]       i_off, d_off;
    logic [WORD_W-1:0] data_in_q, data_in_d, mmio_data_q, mmio_data_d;
    logic              mmio_valid_q, mmio_valid_d, mmio_wr_q, mmio_wr_d;

    mips_mem_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_loader (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .cpu_reset(cpu_reset),
        .load_err(load_err), .run(run), .we(ld_we), .widx(ld_widx), .wdata(ld_wdata)
    );

    // Loader writes only outside RUN and the core only in RUN, so the mux never contends.
    always_comb begin
        i_off        = instr_addr - BASE_ADDR;
        d_off        = data_addr - BASE_ADDR;
        i_hit        = i_off < SPAN;
        d_mmio       = MMIO_EN && data_addr == MMIO_ADDR;
        d_hit        = d_off < SPAN && !d_mmio;
        instr_in     = i_hit ? mem[i_off[AW+1:2]] : '0;
        mem_we       = ld_we || (run && !data_rd_wr && d_hit);
        mem_widx     = ld_we ? ld_widx : d_off[AW+1:2];
        mem_wdata    = ld_we ? ld_wdata : data_out;
        data_in_d    = run ? (d_hit ? mem[d_off[AW+1:2]] : '0) : data_in_q;
        mmio_wr_d    = run && !data_rd_wr && d_mmio;
        mmio_valid_d = mmio_wr_d && !mmio_wr_q;
        mmio_data_d  = mmio_valid_d ? data_out : mmio_data_q;
    end

    always_ff @(posedge clk)
        if (mem_we)
            mem[mem_widx] <= mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_in_q    <= '0;
            mmio_valid_q <= 1'b0;
            mmio_data_q  <= '0;
            mmio_wr_q    <= 1'b0;
        end else begin
            data_in_q    <= data_in_d;
            mmio_valid_q <= mmio_valid_d;
            mmio_data_q  <= mmio_data_d;
            mmio_wr_q    <= mmio_wr_d;
        end
    end

    assign data_in    = data_in_q;
    assign mmio_valid = mmio_valid_q;
    assign mmio_data  = mmio_data_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: randomized self-checking bench with an array-based memory model.
module tb_mips_mem_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;

    logic        clk = 1'b0, reset = 1'b1;
    logic        ld_valid = 1'b0, ld_ready, ld_last = 1'b0, cpu_reset, load_err;
    logic [31:0] ld_data = '0, instr_addr = BASE, instr_in, data_addr = BASE;
    logic        data_rd_wr = 1'b1, mmio_valid;
    logic [31:0] data_out = '0, data_in, mmio_data;

    logic [31:0] model [DEPTH];
    int errors = 0, checks = 0;

    mips_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .cpu_reset(cpu_reset), .load_err(load_err),
        .instr_addr(instr_addr), .instr_in(instr_in), .data_addr(data_addr),
        .data_rd_wr(data_rd_wr), .data_out(data_out), .data_in(data_in),
        .mmio_valid(mmio_valid), .mmio_data(mmio_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'(DEPTH * 4)) ? model[off[31:2]] : 32'h0;
    endfunction

    function automatic bit in_ram(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        ld_valid = 1'b0;
        data_rd_wr = 1'b1;
        step;
        reset = 1'b0;
        #1;
    endtask

    task automatic stream(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = (i == last_at);
            checks += 2;
            if (ld_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, ld_ready); end
            if (cpu_reset !== 1'b1) begin errors++; $display("FAIL stream_cpu_reset[%0d] got %b exp 1", i, cpu_reset); end
            model[i] = ld_data;
            step;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic check_fetch_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            instr_addr = BASE + 32'(i * 4) + 32'($urandom_range(0, 3));
            #1;
            checks++;
            if (instr_in !== model[i]) begin
                errors++;
                $display("FAIL %s fetch[%0d] got %h exp %h", tag, i, instr_in, model[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        checks += 6;
        if (ld_ready !== 1'b0)   begin errors++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
        if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
        if (load_err !== 1'b0)   begin errors++; $display("FAIL rst_load_err got %b exp 0", load_err); end
        if (data_in !== 32'h0)   begin errors++; $display("FAIL rst_data_in got %h exp 0", data_in); end
        if (mmio_valid !== 1'b0) begin errors++; $display("FAIL rst_mmio_valid got %b exp 0", mmio_valid); end
        if (mmio_data !== 32'h0) begin errors++; $display("FAIL rst_mmio_data got %h exp 0", mmio_data); end
        reset = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ld_ready got %b exp 1", ld_ready); end
    endtask

    task automatic test_overflow;
        stream(DEPTH - 1, -1);
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL ovf_early_err got %b exp 0", load_err); end
        ld_valid = 1'b1;
        ld_data  = $urandom;
        model[DEPTH-1] = ld_data;
        step;
        for (int c = 0; c < 5; c++) begin
            checks += 3;
            if (load_err !== 1'b1)  begin errors++; $display("FAIL ovf_err[%0d] got %b exp 1", c, load_err); end
            if (ld_ready !== 1'b0)  begin errors++; $display("FAIL ovf_ready[%0d] got %b exp 0", c, ld_ready); end
            if (cpu_reset !== 1'b1) begin errors++; $display("FAIL ovf_cpu_reset[%0d] got %b exp 1", c, cpu_reset); end
            ld_data = $urandom;
            ld_last = 1'b1;
            step;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_fetch_all("ovf");
    endtask

    task automatic test_reset_mid_load;
        apply_reset;
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL mid_err_cleared got %b exp 0", load_err); end
        stream(2, -1);
        apply_reset;
        stream(4, 3);
        checks += 2;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL mid_cpu_reset got %b exp 0", cpu_reset); end
        if (load_err !== 1'b0)  begin errors++; $display("FAIL mid_load_err got %b exp 0", load_err); end
        check_fetch_all("mid");
    endtask

    task automatic test_exact_fit;
        apply_reset;
        stream(DEPTH, DEPTH - 1);
        checks += 3;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL fit_cpu_reset got %b exp 0", cpu_reset); end
        if (load_err !== 1'b0)  begin errors++; $display("FAIL fit_load_err got %b exp 0", load_err); end
        if (ld_ready !== 1'b0)  begin errors++; $display("FAIL fit_ld_ready got %b exp 0", ld_ready); end
        ld_valid = 1'b1;
        repeat (4) begin
            ld_data = $urandom;
            step;
        end
        ld_valid = 1'b0;
        check_fetch_all("fit");
    endtask

    task automatic test_load;
        apply_reset;
        stream(3, 2);
        checks++;
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_cpu_reset got %b exp 0", cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            instr_addr = BASE + 32'(i * 4);
            #1;
            checks++;
            if (instr_in !== model[i]) begin errors++; $display("FAIL load_fetch[%0d] got %h exp %h", i, instr_in, model[i]); end
        end
    endtask

    task automatic test_store;
        logic [31:0] old, v;
        data_rd_wr = 1'b0;
        data_addr  = BASE + 32'h10;
        data_out   = 32'hDEAD_BEEF;
        repeat (3) step;
        model[4]   = 32'hDEAD_BEEF;
        data_rd_wr = 1'b1;
        step;
        checks++;
        if (data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_readback got %h exp deadbeef", data_in); end
        old = model[5];
        v = $urandom;
        data_addr  = BASE + 32'h14;
        data_rd_wr = 1'b0;
        data_out   = v;
        step;
        checks++;
        if (data_in !== old) begin errors++; $display("FAIL rdw_old got %h exp %h", data_in, old); end
        model[5]   = v;
        data_rd_wr = 1'b1;
        step;
        checks++;
        if (data_in !== v) begin errors++; $display("FAIL rdw_new got %h exp %h", data_in, v); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] addrs [4];
        addrs = '{BASE + 32'(DEPTH * 4), BASE - 32'd4, BASE + 32'(DEPTH * 4) + 32'd3, 32'hFFFF_FFFC};
        foreach (addrs[k]) begin
            data_rd_wr = 1'b0;
            data_addr  = addrs[k];
            data_out   = $urandom;
            repeat (3) step;
            data_rd_wr = 1'b1;
            step;
            instr_addr = addrs[k];
            #1;
            checks += 2;
            if (data_in !== 32'h0)  begin errors++; $display("FAIL oor_data_in[%0d] got %h exp 0", k, data_in); end
            if (instr_in !== 32'h0) begin errors++; $display("FAIL oor_instr_in[%0d] got %h exp 0", k, instr_in); end
        end
        check_fetch_all("oor");
    endtask

    task automatic test_random_rw;
        logic [31:0] a, exp, off;
        bit wr;
        for (int c = 0; c < 300; c++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
                1:       a = BASE - 32'($urandom_range(1, 256));
                default: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            wr         = ($urandom_range(0, 1) == 1);
            data_addr  = a;
            data_rd_wr = !wr;
            data_out   = $urandom;
            instr_addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            exp        = exp_word(a);
            step;
            if (wr && in_ram(a)) begin
                off = a - BASE;
                model[off[31:2]] = data_out;
            end
            checks += 2;
            if (data_in !== exp) begin errors++; $display("FAIL rand_data_in[%0d] addr %h got %h exp %h", c, a, data_in, exp); end
            if (instr_in !== exp_word(instr_addr)) begin
                errors++;
                $display("FAIL rand_instr_in[%0d] addr %h got %h exp %h", c, instr_addr, instr_in, exp_word(instr_addr));
            end
        end
        data_rd_wr = 1'b1;
    endtask

    task automatic mmio_run(input logic [31:0] v, input int n, inout int pulses);
        data_rd_wr = 1'b0;
        data_addr  = MMIO;
        data_out   = v;
        repeat (n) begin
            step;
            pulses += int'(mmio_valid);
        end
    endtask

    task automatic idle_count(inout int pulses);
        data_rd_wr = 1'b1;
        data_addr  = BASE;
        repeat (3) begin
            step;
            pulses += int'(mmio_valid);
        end
    endtask

`ifdef MIPS_MEM_MMIO_EN
    task automatic test_mmio;
        int pulses;
        pulses = 0;
        mmio_run(32'h41, 4, pulses);
        idle_count(pulses);
        checks += 2;
        if (pulses != 1)            begin errors++; $display("FAIL mmio_pulses1 got %0d exp 1", pulses); end
        if (mmio_data !== 32'h41)   begin errors++; $display("FAIL mmio_data1 got %h exp 41", mmio_data); end
        check_fetch_all("mmio");
        pulses = 0;
        mmio_run(32'h42, 2, pulses);
        idle_count(pulses);
        checks += 2;
        if (pulses != 1)            begin errors++; $display("FAIL mmio_pulses2 got %0d exp 1", pulses); end
        if (mmio_data !== 32'h42)   begin errors++; $display("FAIL mmio_data2 got %h exp 42", mmio_data); end
        pulses = 0;
        mmio_run(32'h43, 2, pulses);
        data_addr = BASE + 32'h8;
        data_out  = 32'h1234_5678;
        step;
        pulses += int'(mmio_valid);
        model[2] = 32'h1234_5678;
        mmio_run(32'h44, 2, pulses);
        idle_count(pulses);
        checks += 2;
        if (pulses != 2)            begin errors++; $display("FAIL mmio_pulses_b2b got %0d exp 2", pulses); end
        if (mmio_data !== 32'h44)   begin errors++; $display("FAIL mmio_data_b2b got %h exp 44", mmio_data); end
        data_addr = MMIO;
        step;
        checks++;
        if (data_in !== 32'h0)      begin errors++; $display("FAIL mmio_read got %h exp 0", data_in); end
        check_fetch_all("mmio_b2b");
    endtask
`else
    task automatic test_mmio;
        int pulses;
        pulses = 0;
        mmio_run(32'h41, 4, pulses);
        idle_count(pulses);
        checks += 2;
        if (pulses != 0)          begin errors++; $display("FAIL nommio_pulses got %0d exp 0", pulses); end
        if (mmio_data !== 32'h0)  begin errors++; $display("FAIL nommio_data got %h exp 0", mmio_data); end
        check_fetch_all("nommio");
    endtask
`endif

    initial begin
        test_reset;
        test_overflow;
        test_reset_mid_load;
        test_exact_fit;
        test_load;
        test_store;
        test_out_of_range;
        test_random_rw;
        test_mmio;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
